ex_muldiv: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage. It consumes the `ALUop`, `signed` and operand outputs that ID registers into EX, and computes 64-bit `MULT`/`DIV` results for the HI/LO registers. It raises `pauseRequest_o` to the stall controller while an operation is in flight. Results are presented in the same format as the EX HI/LO bypass (`writeHILO`, HI data, LO data) so that ID forwarding works unchanged.

---
 rtl/ex_muldiv_pkg.sv | 21 ++
 rtl/ex_muldiv_div_iter.sv | 25 ++
 rtl/ex_muldiv.sv | 144 ++++++++++++++
 tb/tb_ex_muldiv.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_NOP  = 5'h00;
    localparam logic [4:0] ALU_MULT = 5'h18;
    localparam logic [4:0] ALU_DIV  = 5'h1A;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_DIV  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Two's-complement magnitude when the value is treated as signed; 0x80000000 stays 0x80000000.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// One restoring-division step: shift {rem, quot} left, trial-subtract the divisor from rem.
module ex_muldiv_div_iter
    import ex_muldiv_pkg::*;
(
    input  logic [2*XLEN-1:0] rq_i,
    input  logic [XLEN-1:0]   divisor_i,
    output logic [2*XLEN-1:0] rq_o
);

    logic [XLEN:0] shifted_rem;
    logic [XLEN:0] diff;

    // The remainder is always below the divisor, so the bit shifted out of rem is the 33rd trial bit.
    assign shifted_rem = rq_i[2*XLEN-1:XLEN-1];
    assign diff        = shifted_rem - {1'b0, divisor_i};

    always_comb begin
        if (!diff[XLEN]) begin
            rq_o = {diff[XLEN-1:0], rq_i[XLEN-2:0], 1'b1};
        end else begin
            rq_o = {rq_i[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/DIV unit for EX: single-cycle multiply, 32-step restoring divide,
// results delivered in HI/LO bypass format with a stall request while busy.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ALUop_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] oprand1_i,
    input  logic [XLEN-1:0] oprand2_i,
    input  logic            flush_i,
    output logic            pauseRequest_o,
    output logic            valid_o,
    output logic [1:0]      writeHILO_o,
    output logic [XLEN-1:0] HI_o,
    output logic [XLEN-1:0] LO_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] rq_q, rq_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              is_mult, is_div;
    logic [2*XLEN-1:0] mul_a, mul_b, product;
    logic [2*XLEN-1:0] rq_step;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    assign is_mult = (ALUop_i == ALU_MULT);
    assign is_div  = (ALUop_i == ALU_DIV);

    // Sign-extending to 64 bits lets one unsigned multiplier give the correct low 64 bits for both modes.
    assign mul_a   = {{XLEN{signed_i & oprand1_i[XLEN-1]}}, oprand1_i};
    assign mul_b   = {{XLEN{signed_i & oprand2_i[XLEN-1]}}, oprand2_i};
    assign product = mul_a * mul_b;

    ex_muldiv_div_iter u_div_iter (
        .rq_i      (rq_q),
        .divisor_i (dvs_q),
        .rq_o      (rq_step)
    );

    assign quot_fix = neg_quot_q ? -rq_step[XLEN-1:0]      : rq_step[XLEN-1:0];
    assign rem_fix  = neg_rem_q  ? -rq_step[2*XLEN-1:XLEN] : rq_step[2*XLEN-1:XLEN];

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rq_d       = rq_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        valid_d    = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            MD_IDLE: begin
                if (is_mult) begin
                    hi_d    = product[2*XLEN-1:XLEN];
                    lo_d    = product[XLEN-1:0];
                    valid_d = 1'b1;
                    state_d = MD_DONE;
                end else if (is_div && oprand2_i == '0) begin
                    hi_d    = oprand1_i;
                    lo_d    = '1;
                    valid_d = 1'b1;
                    state_d = MD_DONE;
                end else if (is_div) begin
                    rq_d       = {{XLEN{1'b0}}, magnitude(oprand1_i, signed_i)};
                    dvs_d      = magnitude(oprand2_i, signed_i);
                    neg_quot_d = signed_i & (oprand1_i[XLEN-1] ^ oprand2_i[XLEN-1]);
                    neg_rem_d  = signed_i & oprand1_i[XLEN-1];
                    cnt_d      = '0;
                    state_d    = MD_DIV;
                end
            end
            MD_DIV: begin
                rq_d  = rq_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    hi_d    = rem_fix;
                    lo_d    = quot_fix;
                    valid_d = 1'b1;
                    state_d = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase

        if (flush_i) begin
            state_d = MD_IDLE;
            valid_d = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            rq_q       <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            valid_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rq_q       <= rq_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            valid_q    <= valid_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign pauseRequest_o = ((state_q == MD_IDLE) && (is_mult || is_div) && !flush_i)
                          || (state_q == MD_DIV);
    assign valid_o        = valid_q;
    assign writeHILO_o    = valid_q ? 2'b11 : 2'b00;
    assign HI_o           = hi_q;
    assign LO_o           = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random MULT/DIV
// compared against an arithmetic reference model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  alu_op;
    logic        sgn;
    logic [31:0] op1, op2;
    logic        flush;
    logic        pause, valid;
    logic [1:0]  write_hilo;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    ex_muldiv dut (
        .clk            (clk),
        .rst            (rst),
        .ALUop_i        (alu_op),
        .signed_i       (sgn),
        .oprand1_i      (op1),
        .oprand2_i      (op2),
        .flush_i        (flush),
        .pauseRequest_o (pause),
        .valid_o        (valid),
        .writeHILO_o    (write_hilo),
        .HI_o           (hi),
        .LO_o           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [4:0] op, input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] e_hi, output logic [31:0] e_lo, output int e_lat);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == ALU_MULT) begin
            p = s ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
            e_hi = p[63:32]; e_lo = p[31:0]; e_lat = 1;
        end else if (b == 0) begin
            e_hi = a; e_lo = 32'hFFFF_FFFF; e_lat = 1;
        end else if (s) begin
            q = sa / sb; r = sa % sb;
            e_hi = r[31:0]; e_lo = q[31:0]; e_lat = 33;
        end else begin
            e_hi = a % b; e_lo = a / b; e_lat = 33;
        end
    endtask

    // Issue at posedge+1; hold the op while stalled; returns at posedge+1 after the valid cycle.
    task automatic run_op(input string tag, input logic [4:0] op, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_hi, e_lo;
        int e_lat, n;
        bit seen;
        model(op, s, a, b, e_hi, e_lo, e_lat);
        alu_op = op; sgn = s; op1 = a; op2 = b;
        n = 0; seen = 0;
        while (n <= 40 && !seen) begin
            @(negedge clk);
            if (valid) seen = 1;
            else begin
                check({tag, "_pause"}, 64'(pause), 64'(1));
                @(posedge clk); #1;
                n++;
            end
        end
        check({tag, "_latency"}, 64'(n), 64'(e_lat));
        if (seen) begin
            check({tag, "_pause_done"}, 64'(pause), 64'(0));
            check({tag, "_whilo"}, 64'(write_hilo), 64'(2'b11));
            check({tag, "_hi"}, 64'(hi), 64'(e_hi));
            check({tag, "_lo"}, 64'(lo), 64'(e_lo));
            last_hi = e_hi; last_lo = e_lo;
            @(posedge clk); #1;
        end
        alu_op = ALU_NOP;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit any_valid, any_pause;
        rst = 1'b0; alu_op = ALU_NOP; sgn = 1'b0; op1 = '0; op2 = '0; flush = 1'b0;
        #1;
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_whilo", 64'(write_hilo), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_pause", 64'(pause), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        run_op("mulu_max", ALU_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divs_m7_2", ALU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", ALU_DIV, 1'b0, 32'd100, 32'd7);
        run_op("mul_3_4", ALU_MULT, 1'b0, 32'd3, 32'd4);
        run_op("div_by0", ALU_DIV, 1'b0, 32'd5, 32'd0);
        run_op("divs_min_m1", ALU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("muls_neg", ALU_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7);

        // Flush mid-division: no result, HI/LO keep the previous values.
        alu_op = ALU_DIV; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3;
        repeat (10) begin
            @(negedge clk); check("flush_pause_busy", 64'(pause), 64'(1));
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; alu_op = ALU_NOP;
        any_valid = 0; any_pause = 0;
        repeat (40) begin
            @(negedge clk);
            any_valid |= valid; any_pause |= pause;
        end
        check("flush_no_valid", 64'(any_valid), 64'(0));
        check("flush_idle", 64'(any_pause), 64'(0));
        check("flush_hi_kept", 64'(hi), 64'(last_hi));
        check("flush_lo_kept", 64'(lo), 64'(last_lo));
        @(posedge clk); #1;

        // Asynchronous reset mid-division.
        alu_op = ALU_DIV; sgn = 1'b1; op1 = 32'hFFFF_0000; op2 = 32'd9;
        repeat (20) begin @(posedge clk); #1; end
        #2 rst = 1'b0; alu_op = ALU_NOP;
        #1;
        check("arst_valid", 64'(valid), 64'(0));
        check("arst_whilo", 64'(write_hilo), 64'(0));
        check("arst_hi", 64'(hi), 64'(0));
        check("arst_lo", 64'(lo), 64'(0));
        check("arst_pause", 64'(pause), 64'(0));
        last_hi = '0; last_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        any_valid = 0;
        repeat (40) begin @(negedge clk); any_valid |= valid; end
        check("arst_no_valid", 64'(any_valid), 64'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            logic [31:0] a, b;
            op = $urandom_range(0, 1) ? ALU_MULT : ALU_DIV;
            a = pick();
            b = ($urandom_range(0, 9) == 0) ? 32'h0 : pick();
            run_op("rand", op, 1'($urandom_range(0, 1)), a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
